// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1, 2-of-3 majority sampling at mid-bit
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rbyte_ready,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int          H    = CLKS_PER_BIT / 2;
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HM1  = 16'(H - 1);
    localparam logic [15:0] HC   = 16'(H);
    localparam logic [15:0] HP1  = 16'(H + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic        rx_meta, rxs, rxs_q;
    logic [1:0]  fill_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  samp_q, samp_d;
    logic [7:0]  data_d;
    logic        ready_d, err_d;
    logic        maj;

    // Two-flop synchronizer plus a delayed copy for edge detection; fill_q
    // counts until both rxs and rxs_q hold real line samples so that a line
    // already low at reset release is not mistaken for a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
            fill_q  <= 2'd0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
            if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
        end
    end

    // Majority of the samples taken at H-1, H and the live one at H+1.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    // Receiver state, bit timing, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            bit_q       <= 3'd0;
            shreg_q     <= 8'd0;
            samp_q      <= 2'b00;
            rx_data     <= 8'd0;
            rbyte_ready <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            samp_q      <= samp_d;
            rx_data     <= data_d;
            rbyte_ready <= ready_d;
            frame_err   <= err_d;
        end
    end

    // Next-state logic: the bit decision is made at H+1 in every sampled state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        samp_d  = samp_q;
        data_d  = rx_data;
        ready_d = 1'b0;
        err_d   = 1'b0;

        if (cnt_q == HM1) samp_d[0] = rxs;
        if (cnt_q == HC)  samp_d[1] = rxs;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                bit_d = 3'd0;
                if (fill_q == 2'd3 && rxs_q && !rxs) state_d = START;
            end
            START: begin
                if (cnt_q == HP1 && maj) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == LAST) begin
                    state_d = DATA;
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q == HP1) shreg_d = {maj, shreg_q[7:1]};
                if (cnt_q == LAST) begin
                    cnt_d = 16'd0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at the decision point so a following start edge is not missed.
                if (cnt_q == HP1) begin
                    cnt_d = 16'd0;
                    if (maj) begin
                        data_d  = shreg_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // Count consecutive high cycles; any low sample restarts the wait.
                if (!rxs) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == LAST) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int C = 217;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rbyte_ready, frame_err, rx_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    int last_pulse_cyc = 0;
    logic [7:0] got[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rbyte_ready(rbyte_ready),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rbyte_ready) begin
            ready_cnt++;
            last_pulse_cyc = cyc;
            got.push_back(rx_data);
        end
        if (frame_err) err_cnt++;
        if (rbyte_ready && frame_err) both_cnt++;
        if (rx_busy) busy_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        clks(C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopv, output int fall_cyc);
        fall_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stopv);
    endtask

    // Data bits carry a one-cycle low glitch near the mid-bit sample point.
    task automatic send_frame_glitch(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clks(H + 1);
            rx = 1'b0;
            clks(1);
            rx = d[i];
            clks(C - H - 2);
        end
        send_bit(1'b1);
    endtask

    int fc, r0, e0, b0, n0, lat, k;

    initial begin
        // Reset state
        rst = 1'b0;
        rx  = 1'b1;
        clks(5);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_ready", rbyte_ready, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        rst = 1'b1;
        clks(2 * C);

        // Scenario 1: single byte, latency
        r0 = ready_cnt; e0 = err_cnt;
        send_frame(8'h7E, 1'b1, fc);
        clks(20);
        check("s1_pulses", ready_cnt - r0, 1);
        check("s1_data", rx_data, 8'h7E);
        check("s1_ferr", err_cnt - e0, 0);
        lat = last_pulse_cyc - fc;
        check_range("s1_latency", lat, 4 + 9 * C + H - 1, 4 + 9 * C + H + 1);

        // Scenario 2: back-to-back frames
        r0 = ready_cnt; e0 = err_cnt; n0 = got.size();
        send_frame(8'h7E, 1'b1, fc);
        send_frame(8'h30, 1'b1, fc);
        send_frame(8'h5F, 1'b1, fc);
        clks(20);
        check("s2_pulses", ready_cnt - r0, 3);
        if (got.size() >= n0 + 3) begin
            check("s2_byte0", got[n0], 8'h7E);
            check("s2_byte1", got[n0 + 1], 8'h30);
            check("s2_byte2", got[n0 + 2], 8'h5F);
        end else begin
            check("s2_queue_size", got.size() - n0, 3);
        end
        check("s2_ferr", err_cnt - e0, 0);

        // Scenario 3: false start
        r0 = ready_cnt; e0 = err_cnt; b0 = busy_cnt;
        rx = 1'b0;
        clks(50);
        rx = 1'b1;
        clks(2 * C);
        check("s3_pulses", ready_cnt - r0, 0);
        check("s3_ferr", err_cnt - e0, 0);
        check_range("s3_busy_cycles", busy_cnt - b0, H + 1, H + 4);
        check("s3_busy_end", rx_busy, 1'b0);
        check("s3_data_held", rx_data, 8'h5F);

        // Scenario 4: framing error followed by a held-low line
        r0 = ready_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b0, fc);
        clks(5 * C);
        check("s4_busy_in_break", rx_busy, 1'b1);
        rx = 1'b1;
        k = 0;
        while (rx_busy && k < 3 * C) begin
            clks(1);
            k++;
        end
        check_range("s4_busy_fall", k, C, C + 3);
        check("s4_ferr", err_cnt - e0, 1);
        check("s4_pulses", ready_cnt - r0, 0);
        check("s4_data_held", rx_data, 8'h5F);
        clks(C);

        // Scenario 6: glitches inside data bits
        r0 = ready_cnt; e0 = err_cnt;
        send_frame_glitch(8'h0F);
        clks(20);
        check("s6_pulses", ready_cnt - r0, 1);
        check("s6_data", rx_data, 8'h0F);
        check("s6_ferr", err_cnt - e0, 0);

        // Scenario 5: reset mid-frame, line low at release, then a clean frame
        r0 = ready_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h55 >> i));
        rx = 1'b1;
        clks(C / 2);
        rst = 1'b0;
        rx  = 1'b0;
        clks(4);
        check("s5_rst_data", rx_data, 8'h00);
        check("s5_rst_busy", rx_busy, 1'b0);
        rst = 1'b1;
        clks(3 * C);
        check("s5_low_release_busy", rx_busy, 1'b0);
        check("s5_abort_pulses", ready_cnt - r0, 0);
        rx = 1'b1;
        clks(2 * C);
        send_frame(8'h3C, 1'b1, fc);
        clks(20);
        check("s5_pulses", ready_cnt - r0, 1);
        check("s5_data", rx_data, 8'h3C);
        check("s5_ferr", err_cnt - e0, 0);

        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217 (25 MHz / 115200 baud), meaning clk cycles per UART bit; legal range 8..65535.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-005 The block SHALL have port rx_data  output  8  last correctly framed byte; feeds the command parser's rx_data.
REQ-006 The block SHALL have port rbyte_ready  output  1  one-cycle pulse marking a new valid byte on rx_data.
REQ-007 The block SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized signal rxs, 2 cycles behind rx.
REQ-010 The state machine SHALL have the states IDLE, START, DATA, STOP and BREAK.
REQ-011 A bit counter SHALL count 0..CLKS_PER_BIT-1 within each bit period and restart at 0 on every state or bit transition; H SHALL equal CLKS_PER_BIT/2, truncated.
REQ-012 Each bit value SHALL be the 2-of-3 majority of rxs sampled at counter values H-1, H and H+1; the decision SHALL be made at H+1.
REQ-013 In IDLE, a high-to-low change of rxs SHALL move the FSM to START with the counter at 0.
REQ-014 In START, a majority result of 1 SHALL be a false start: return to IDLE, with no output pulse and rx_data unchanged.
REQ-015 In START, a majority result of 0 SHALL move the FSM to DATA once the counter reaches CLKS_PER_BIT-1.
REQ-016 DATA SHALL capture 8 bits LSB first into a shift register, one bit per bit period, then enter STOP.
REQ-017 In STOP, a majority of 1 SHALL load rx_data with the shift register and pulse rbyte_ready high for exactly 1 cycle; both updates SHALL be registered, appearing the cycle after the decision.
REQ-018 After a stop majority of 1, the FSM SHALL return to IDLE at the decision cycle (not end of bit), allowing back-to-back frames.
REQ-019 In STOP, a majority of 0 SHALL pulse frame_err for 1 cycle, leave rx_data unchanged, assert no rbyte_ready, and enter BREAK.
REQ-020 BREAK SHALL wait until rxs has been high for CLKS_PER_BIT consecutive cycles, then enter IDLE; a line held low SHALL produce no further pulses.
REQ-021 rbyte_ready and frame_err SHALL never be high in the same cycle.
REQ-022 Glitches on rx shorter than 2 cycles within a bit SHALL NOT change a bit decision, by the majority rule.
REQ-023 End-to-end latency, from rx falling at the start-bit edge to the rbyte_ready pulse, SHALL be 2 + 9*CLKS_PER_BIT + H + 2 cycles, within ±1 cycle.

Reset
REQ-024 While rst=0, the outputs SHALL be: rx_data=0x00, rbyte_ready=0, frame_err=0, rx_busy=0.
REQ-025 While rst=0, internally the FSM SHALL be in IDLE, counters and shift register SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no pulse.
REQ-027 After rst rises, the block SHALL require an rxs high-to-low change before starting a new frame; a line already low at release SHALL NOT start a frame.

Verification
REQ-028 Scenario 1: with CLKS_PER_BIT=217, send 0x7E ("~") with 1 stop bit -> exactly one rbyte_ready pulse, rx_data=0x7E, frame_err=0, and the latency of REQ-023.
REQ-029 Scenario 2: send "~", "0", "_" back-to-back with no idle gap -> three pulses with rx_data 0x7E, 0x30, 0x5F in order, and no frame_err.
REQ-030 Scenario 3: drive rx low for 50 cycles (less than H), then high -> false start, no pulses, rx_busy high for about H+3 cycles, then low.
REQ-031 Scenario 4: send 0xA5 with the stop bit low, then hold rx low for 5 bit times, then high -> one frame_err pulse, no rbyte_ready, rx_data holds its previous value, rx_busy falls CLKS_PER_BIT cycles after the line returns high.
REQ-032 Scenario 5: assert rst during bit 4 of 0x55, release, then send 0x3C -> no pulse for the aborted frame, one pulse with rx_data=0x3C.
REQ-033 Scenario 6: send 0x0F with a 1-cycle low glitch at sample point H inside each data bit -> rx_data=0x0F, no frame_err.
